// File: rtl/l1l2_xfer_pkg.sv
// Shared types and constants for the L1/L2 block-transfer buffer.
package l1l2_xfer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR,
    RD,
    DONE
  } xfer_state_e;

  localparam int EXC_L1_OVF  = 0;
  localparam int EXC_L1_UNF  = 1;
  localparam int EXC_L2_OVF  = 2;
  localparam int EXC_L2_UNF  = 3;
  localparam int EXC_TIMEOUT = 4;
  localparam int EXC_W       = 5;

  localparam logic RW_FILL = 1'b0;
  localparam logic RW_WB   = 1'b1;

endpackage

// File: rtl/xfer_fifo.sv
// Synchronous show-ahead FIFO; head reads 0 when empty, next occupancy exported
// so the owner can register its ready flags one cycle ahead.
module xfer_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic [AW:0]       cnt_nxt_o
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign do_push = push_i && (cnt_q != DEPTH_C);
  assign do_pop  = pop_i && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (flush_i)                cnt_d = '0;
    else if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Storage is never reset; the empty mask on data_o hides stale contents.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o    = (cnt_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/l1_l2_xfer_buffer.sv
// L1<->L2 line-fill / write-back staging buffer with sticky protocol exceptions.
// Optional watchdog enabled by defining L1L2_XFER_TIMEOUT_EN.
module l1_l2_xfer_buffer
  import l1l2_xfer_pkg::*;
#(
  parameter int BLOCK_WORDS    = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int ADDR_W         = 24,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              req_i,
  input  logic              rw_i,
  input  logic [ADDR_W-1:0] add_i,
  input  logic              write_en_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              read_ack_i,
  output logic              ready_write_o,
  output logic              ready_read_o,
  output logic [DATA_W-1:0] data_o,
  output logic              xfer_done_o,
  output logic              l2_req_o,
  output logic              l2_rw_o,
  output logic [ADDR_W-1:0] l2_add_o,
  input  logic              l2_ready_i,
  input  logic              l2_valid_i,
  input  logic [DATA_W-1:0] l2_data_i,
  input  logic              l2_read_ack_i,
  output logic [DATA_W-1:0] l2_data_o,
  output logic              l2_ready_read_o,
  output logic              l2_ready_write_o,
  output logic [EXC_W-1:0]  exception_bus_o
);

  localparam int CW = $clog2(BLOCK_WORDS) + 1;
  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] BW_C = CW'(BLOCK_WORDS);
  localparam logic [FW-1:0] FD_C = FW'(FIFO_DEPTH);

  if ((FIFO_DEPTH < BLOCK_WORDS) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least BLOCK_WORDS");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  xfer_state_e       state_q, state_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] add_q, add_d;
  logic [CW-1:0]     push_cnt_q, push_cnt_d, pop_cnt_q, pop_cnt_d;
  logic [EXC_W-1:0]  exc_q, exc_d;
  logic              rdy_wr_q, rdy_wr_d, rdy_rd_q, rdy_rd_d;
  logic              l2_rdy_wr_q, l2_rdy_wr_d, l2_rdy_rd_q, l2_rdy_rd_d;
  logic              l2_req_q, l2_req_d, done_q, done_d;

  logic              l1_push, l2_push, l1_pop, l2_pop;
  logic              fifo_push, fifo_pop, fifo_flush;
  logic [DATA_W-1:0] fifo_wdata, fifo_head;
  logic [FW-1:0]     fifo_cnt_nxt;
  logic              tmo_fire;

  assign l1_push    = write_en_i && rdy_wr_q;
  assign l2_push    = l2_valid_i && l2_rdy_wr_q;
  assign l1_pop     = read_ack_i && rdy_rd_q;
  assign l2_pop     = l2_read_ack_i && l2_rdy_rd_q;
  assign fifo_push  = l1_push || l2_push;
  assign fifo_pop   = l1_pop || l2_pop;
  assign fifo_wdata = (rw_q == RW_WB) ? data_i : l2_data_i;

  xfer_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk_i     (clock_i),
    .rst_i     (reset_i),
    .flush_i   (fifo_flush),
    .push_i    (fifo_push),
    .data_i    (fifo_wdata),
    .pop_i     (fifo_pop),
    .data_o    (fifo_head),
    .cnt_nxt_o (fifo_cnt_nxt)
  );

`ifdef L1L2_XFER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_fire = (state_q != IDLE) && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Any progress (state change or accepted word) restarts the watchdog.
  always_comb begin
    tmo_cnt_d = '0;
    if ((state_q != IDLE) && (state_d == state_q) && !fifo_push && !fifo_pop && !tmo_fire)
      tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) tmo_cnt_q <= '0;
    else         tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    add_d      = add_q;
    exc_d      = exc_q;
    fifo_flush = 1'b0;
    push_cnt_d = (fifo_push && (push_cnt_q < BW_C)) ? push_cnt_q + 1'b1 : push_cnt_q;
    pop_cnt_d  = (fifo_pop && (pop_cnt_q < BW_C)) ? pop_cnt_q + 1'b1 : pop_cnt_q;

    if (write_en_i && !rdy_wr_q)       exc_d[EXC_L1_OVF] = 1'b1;
    if (read_ack_i && !rdy_rd_q)       exc_d[EXC_L1_UNF] = 1'b1;
    if (l2_valid_i && !l2_rdy_wr_q)    exc_d[EXC_L2_OVF] = 1'b1;
    if (l2_read_ack_i && !l2_rdy_rd_q) exc_d[EXC_L2_UNF] = 1'b1;

    unique case (state_q)
      IDLE: if (req_i) begin
        rw_d    = rw_i;
        add_d   = add_i;
        state_d = CMD;
      end
      CMD: if (l2_ready_i) state_d = (rw_q == RW_WB) ? WR : RD;
      WR, RD: if (pop_cnt_d == BW_C) state_d = DONE;
      DONE: if (!req_i) begin
        state_d    = IDLE;
        fifo_flush = 1'b1;
        push_cnt_d = '0;
        pop_cnt_d  = '0;
      end
      default: state_d = IDLE;
    endcase

    if (tmo_fire) begin
      exc_d[EXC_TIMEOUT] = 1'b1;
      fifo_flush         = 1'b1;
      state_d            = DONE;
    end

    // Write-back words may be staged while the L2 command is still pending.
    rdy_wr_d    = ((state_d == WR) || ((state_d == CMD) && (rw_d == RW_WB)))
                  && (fifo_cnt_nxt != FD_C) && (push_cnt_d < BW_C);
    l2_rdy_rd_d = (state_d == WR) && (fifo_cnt_nxt != '0);
    l2_rdy_wr_d = (state_d == RD) && (fifo_cnt_nxt != FD_C) && (push_cnt_d < BW_C);
    rdy_rd_d    = (state_d == RD) && (fifo_cnt_nxt != '0);
    l2_req_d    = (state_d == CMD);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      rw_q        <= RW_FILL;
      add_q       <= '0;
      push_cnt_q  <= '0;
      pop_cnt_q   <= '0;
      exc_q       <= '0;
      rdy_wr_q    <= 1'b0;
      rdy_rd_q    <= 1'b0;
      l2_rdy_wr_q <= 1'b0;
      l2_rdy_rd_q <= 1'b0;
      l2_req_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      add_q       <= add_d;
      push_cnt_q  <= push_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      exc_q       <= exc_d;
      rdy_wr_q    <= rdy_wr_d;
      rdy_rd_q    <= rdy_rd_d;
      l2_rdy_wr_q <= l2_rdy_wr_d;
      l2_rdy_rd_q <= l2_rdy_rd_d;
      l2_req_q    <= l2_req_d;
      done_q      <= done_d;
    end
  end

  assign ready_write_o    = rdy_wr_q;
  assign ready_read_o     = rdy_rd_q;
  assign l2_ready_write_o = l2_rdy_wr_q;
  assign l2_ready_read_o  = l2_rdy_rd_q;
  assign xfer_done_o      = done_q;
  assign l2_req_o         = l2_req_q;
  assign l2_rw_o          = rw_q;
  assign l2_add_o         = add_q;
  assign data_o           = fifo_head;
  assign l2_data_o        = fifo_head;
  assign exception_bus_o  = exc_q;

endmodule

// File: tb/tb_l1_l2_xfer_buffer.sv
// Directed testbench for l1_l2_xfer_buffer (fill, write-back, streaming, errors, reset, watchdog).
module tb_l1_l2_xfer_buffer;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset_i = 1'b0, req_i = 1'b0, rw_i = 1'b0;
  logic [ADDR_W-1:0] add_i = '0;
  logic              write_en_i = 1'b0, read_ack_i = 1'b0;
  logic [DATA_W-1:0] data_i = '0, l2_data_i = '0;
  logic              l2_ready_i = 1'b0, l2_valid_i = 1'b0, l2_read_ack_i = 1'b0;
  logic              ready_write_o, ready_read_o, xfer_done_o, l2_req_o, l2_rw_o;
  logic              l2_ready_read_o, l2_ready_write_o;
  logic [ADDR_W-1:0] l2_add_o;
  logic [DATA_W-1:0] data_o, l2_data_o;
  logic [4:0]        exception_bus_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  l1_l2_xfer_buffer #(
    .BLOCK_WORDS(4), .FIFO_DEPTH(8), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(16)
  ) dut (
    .clock_i(clk), .reset_i(reset_i), .req_i(req_i), .rw_i(rw_i), .add_i(add_i),
    .write_en_i(write_en_i), .data_i(data_i), .read_ack_i(read_ack_i),
    .ready_write_o(ready_write_o), .ready_read_o(ready_read_o), .data_o(data_o),
    .xfer_done_o(xfer_done_o), .l2_req_o(l2_req_o), .l2_rw_o(l2_rw_o), .l2_add_o(l2_add_o),
    .l2_ready_i(l2_ready_i), .l2_valid_i(l2_valid_i), .l2_data_i(l2_data_i),
    .l2_read_ack_i(l2_read_ack_i), .l2_data_o(l2_data_o), .l2_ready_read_o(l2_ready_read_o),
    .l2_ready_write_o(l2_ready_write_o), .exception_bus_o(exception_bus_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic rw, input logic [ADDR_W-1:0] add);
    req_i = 1'b1; rw_i = rw; add_i = add;
    tick();
    l2_ready_i = 1'b1;
    tick();
    l2_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    tick(); tick();
    reset_i = 1'b0;
    total_cnt++;
    if ({ready_write_o, ready_read_o, xfer_done_o, l2_req_o, l2_rw_o, l2_ready_read_o, l2_ready_write_o} !== 7'b0)
      $display("FAIL reset_ctrl: got %b want 0", {ready_write_o, ready_read_o, xfer_done_o, l2_req_o, l2_rw_o, l2_ready_read_o, l2_ready_write_o});
    else pass_cnt++;
    total_cnt++;
    if (l2_add_o !== 24'h0) $display("FAIL reset_add: got %h want 0", l2_add_o); else pass_cnt++;
    total_cnt++;
    if ({data_o, l2_data_o} !== 64'h0) $display("FAIL reset_data: got %h/%h want 0", data_o, l2_data_o); else pass_cnt++;
    total_cnt++;
    if (exception_bus_o !== 5'b0) $display("FAIL reset_exc: got %b want 0", exception_bus_o); else pass_cnt++;
  endtask

  task automatic test_fill();
    req_i = 1'b1; rw_i = 1'b0; add_i = 24'h000100;
    tick();
    add_i = 24'hFFFFFF;
    total_cnt++;
    if ({l2_req_o, l2_rw_o, l2_add_o} !== {1'b1, 1'b0, 24'h000100})
      $display("FAIL fill_cmd: got req=%b rw=%b add=%h want 1 0 000100", l2_req_o, l2_rw_o, l2_add_o);
    else pass_cnt++;
    tick(); tick();
    total_cnt++;
    if ({l2_req_o, l2_add_o} !== {1'b1, 24'h000100})
      $display("FAIL fill_cmd_hold: got req=%b add=%h want 1 000100", l2_req_o, l2_add_o);
    else pass_cnt++;
    l2_ready_i = 1'b1;
    tick();
    l2_ready_i = 1'b0;
    total_cnt++;
    if ({l2_req_o, l2_ready_write_o, ready_read_o} !== 3'b010)
      $display("FAIL fill_enter_rd: got req/l2rw/rr=%b want 010", {l2_req_o, l2_ready_write_o, ready_read_o});
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      l2_valid_i = 1'b1; l2_data_i = 32'hA0 + i;
      tick();
    end
    l2_valid_i = 1'b0;
    total_cnt++;
    if ({l2_ready_write_o, ready_read_o, data_o} !== {2'b01, 32'hA0})
      $display("FAIL fill_staged: got l2rw=%b rr=%b data=%h want 0 1 a0", l2_ready_write_o, ready_read_o, data_o);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if ({ready_read_o, data_o} !== {1'b1, 32'hA0 + i})
        $display("FAIL fill_pop%0d: got rr=%b data=%h want 1 %h", i, ready_read_o, data_o, 32'hA0 + i);
      else pass_cnt++;
      read_ack_i = 1'b1;
      tick();
    end
    read_ack_i = 1'b0;
    total_cnt++;
    if ({xfer_done_o, exception_bus_o} !== 6'b1_00000)
      $display("FAIL fill_done: got done=%b exc=%b want 1 00000", xfer_done_o, exception_bus_o);
    else pass_cnt++;
    req_i = 1'b0;
    tick();
    total_cnt++;
    if (xfer_done_o !== 1'b0) $display("FAIL fill_idle: got done=%b want 0", xfer_done_o); else pass_cnt++;
  endtask

  task automatic test_writeback();
    req_i = 1'b1; rw_i = 1'b1; add_i = 24'h0000F0;
    tick();
    total_cnt++;
    if ({l2_req_o, l2_rw_o, l2_add_o, ready_write_o} !== {2'b11, 24'h0000F0, 1'b1})
      $display("FAIL wb_cmd: got req=%b rw=%b add=%h rw_rdy=%b want 1 1 0000f0 1", l2_req_o, l2_rw_o, l2_add_o, ready_write_o);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      write_en_i = 1'b1; data_i = 32'h11 + i;
      tick();
    end
    write_en_i = 1'b0;
    total_cnt++;
    if ({ready_write_o, l2_ready_read_o, l2_req_o} !== 3'b001)
      $display("FAIL wb_full_block: got rw=%b l2rr=%b req=%b want 0 0 1", ready_write_o, l2_ready_read_o, l2_req_o);
    else pass_cnt++;
    l2_ready_i = 1'b1;
    tick();
    l2_ready_i = 1'b0;
    total_cnt++;
    if ({l2_req_o, l2_ready_read_o} !== 2'b01)
      $display("FAIL wb_enter_wr: got req=%b l2rr=%b want 0 1", l2_req_o, l2_ready_read_o);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if ({l2_ready_read_o, l2_data_o} !== {1'b1, 32'h11 + i})
        $display("FAIL wb_pop%0d: got rdy=%b data=%h want 1 %h", i, l2_ready_read_o, l2_data_o, 32'h11 + i);
      else pass_cnt++;
      l2_read_ack_i = 1'b1;
      tick();
    end
    l2_read_ack_i = 1'b0;
    total_cnt++;
    if ({xfer_done_o, exception_bus_o} !== 6'b1_00000)
      $display("FAIL wb_done: got done=%b exc=%b want 1 00000", xfer_done_o, exception_bus_o);
    else pass_cnt++;
    req_i = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int pushed, popped, max_occ, occ, cycles;
    logic pv, pa;
    pushed = 0; popped = 0; max_occ = 0; cycles = 0;
    start_cmd(1'b0, 24'h000200);
    while (!xfer_done_o && cycles < 20) begin
      pv = l2_ready_write_o && (pushed < 4);
      pa = ready_read_o;
      l2_valid_i = pv; l2_data_i = 32'hB0 + pushed;
      read_ack_i = pa;
      if (pa) begin
        total_cnt++;
        if (data_o !== 32'hB0 + popped)
          $display("FAIL b2b_data%0d: got %h want %h", popped, data_o, 32'hB0 + popped);
        else pass_cnt++;
      end
      tick();
      if (pv) pushed++;
      if (pa) popped++;
      occ = int'(dut.u_fifo.cnt_q);
      if (occ > max_occ) max_occ = occ;
      cycles++;
    end
    l2_valid_i = 1'b0; read_ack_i = 1'b0;
    total_cnt++;
    if ({xfer_done_o, popped, max_occ} !== {1'b1, 32'd4, 32'd1})
      $display("FAIL b2b_summary: got done=%b popped=%0d max_occ=%0d want 1 4 1", xfer_done_o, popped, max_occ);
    else pass_cnt++;
    req_i = 1'b0;
    tick();
  endtask

  task automatic test_protocol_errors();
    start_cmd(1'b0, 24'h000300);
    read_ack_i = 1'b1; write_en_i = 1'b1; data_i = 32'hDEAD;
    tick();
    read_ack_i = 1'b0; write_en_i = 1'b0;
    total_cnt++;
    if (exception_bus_o !== 5'b00011) $display("FAIL err_bits: got %b want 00011", exception_bus_o); else pass_cnt++;
    total_cnt++;
    if ({ready_read_o, l2_ready_write_o, data_o} !== {2'b01, 32'h0})
      $display("FAIL err_fifo: got rr=%b l2rw=%b data=%h want 0 1 0", ready_read_o, l2_ready_write_o, data_o);
    else pass_cnt++;
    reset_i = 1'b1; req_i = 1'b0;
    tick();
    reset_i = 1'b0;
    total_cnt++;
    if ({exception_bus_o, l2_ready_write_o} !== 6'b0)
      $display("FAIL err_clear: got exc=%b l2rw=%b want 0", exception_bus_o, l2_ready_write_o);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_wr();
    int req_seen;
    start_cmd(1'b1, 24'h000400);
    for (int i = 0; i < 2; i++) begin
      write_en_i = 1'b1; data_i = 32'h21 + i;
      tick();
    end
    write_en_i = 1'b0;
    total_cnt++;
    if ({ready_write_o, l2_ready_read_o, l2_data_o} !== {2'b11, 32'h21})
      $display("FAIL midwr_state: got rw=%b l2rr=%b data=%h want 1 1 21", ready_write_o, l2_ready_read_o, l2_data_o);
    else pass_cnt++;
    reset_i = 1'b1; req_i = 1'b0;
    tick();
    reset_i = 1'b0;
    total_cnt++;
    if ({ready_write_o, ready_read_o, l2_ready_read_o, l2_ready_write_o, l2_req_o, xfer_done_o} !== 6'b0 || data_o !== 32'h0)
      $display("FAIL midwr_reset: got rdy=%b data=%h want 000000 0",
               {ready_write_o, ready_read_o, l2_ready_read_o, l2_ready_write_o, l2_req_o, xfer_done_o}, data_o);
    else pass_cnt++;
    req_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (l2_req_o) req_seen++;
    end
    total_cnt++;
    if (req_seen !== 0) $display("FAIL midwr_no_reissue: got %0d req cycles want 0", req_seen); else pass_cnt++;
  endtask

`ifdef L1L2_XFER_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    n = 0;
    req_i = 1'b1; rw_i = 1'b0; add_i = 24'h000500;
    tick();
    while (!xfer_done_o && n < 40) begin
      tick();
      n++;
    end
    total_cnt++;
    if ({n, xfer_done_o, exception_bus_o[4]} !== {32'd16, 2'b11})
      $display("FAIL timeout: got cycles=%0d done=%b exc4=%b want 16 1 1", n, xfer_done_o, exception_bus_o[4]);
    else pass_cnt++;
    req_i = 1'b0;
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_writeback();
    test_back_to_back();
    test_protocol_errors();
    test_reset_mid_wr();
`ifdef L1L2_XFER_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/l1_l2_xfer_buffer.md
Name: l1_l2_xfer_buffer

Overview:
- Block-transfer buffer between the arbitrated L1 port (instruction or data cache, already muxed upstream) and the L2 cache controller.
- Takes one line-fill (read) or write-back (write) request from L1 and issues it to L2 as a single command.
- Stages exactly BLOCK_WORDS data words through an internal FIFO, with independent push/pop handshakes on each side.
- Reports sticky protocol exceptions.

Parameters:
- BLOCK_WORDS, 4: words per cache line moved per request; power of two, 2..16.
- FIFO_DEPTH, 8: staging FIFO depth in words; power of two, at least BLOCK_WORDS.
- ADDR_W, 24: word-address width.
- DATA_W, 32: data word width.
- TIMEOUT_CYCLES, 1024: watchdog limit; used only with the optional feature.

Ports:
- clock_i  in  1  single clock; all logic on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- req_i  in  1  L1 request, level; held until xfer_done_o.
- rw_i  in  1  1 = write-back (L1→L2), 0 = line fill (L2→L1); sampled in IDLE.
- add_i  in  ADDR_W  block base word address; sampled in IDLE.
- write_en_i  in  1  L1 pushes data_i; honoured only when ready_write_o = 1.
- data_i  in  DATA_W  write-back word.
- read_ack_i  in  1  L1 pops data_o; honoured only when ready_read_o = 1.
- ready_write_o  out  1  buffer can accept a write-back word.
- ready_read_o  out  1  fill word is valid on data_o.
- data_o  out  DATA_W  FIFO head, show-ahead.
- xfer_done_o  out  1  transfer complete.
- l2_req_o  out  1  command to L2.
- l2_rw_o  out  1  registered copy of rw_i.
- l2_add_o  out  ADDR_W  registered copy of add_i.
- l2_ready_i  in  1  L2 accepts the command.
- l2_valid_i  in  1  L2 pushes l2_data_i; honoured only when l2_ready_write_o = 1.
- l2_data_i  in  DATA_W  fill word from L2.
- l2_read_ack_i  in  1  L2 pops l2_data_o; honoured only when l2_ready_read_o = 1.
- l2_data_o  out  DATA_W  FIFO head, show-ahead.
- l2_ready_read_o  out  1  write-back word is valid for L2.
- l2_ready_write_o  out  1  buffer can accept a fill word.
- exception_bus_o  out  5  sticky error flags.

Behaviour:
- Reset: FSM to IDLE; FIFO flushed; push/pop counters zeroed.
  - All outputs 0 after reset; data_o and l2_data_o read 0.
  - exception_bus_o cleared.
  - A reset mid-transfer aborts the transfer; no l2_req_o re-issue afterwards.
- FSM states: IDLE, CMD, WR, RD, DONE.
  - IDLE: when req_i = 1, latch rw_i and add_i; go to CMD. l2_req_o rises in the next cycle, so latency is 1 cycle.
  - CMD: hold l2_req_o, l2_rw_o and l2_add_o stable until l2_ready_i = 1. Then drop l2_req_o and go to WR or RD according to the latched rw.
  - WR: ready_write_o = !full && (push_cnt < BLOCK_WORDS); l2_ready_read_o = !empty.
    - L1 may push before L2 starts popping.
    - Exit to DONE when pop_cnt = BLOCK_WORDS.
  - RD: l2_ready_write_o = !full && (push_cnt < BLOCK_WORDS); ready_read_o = !empty.
    - Exit to DONE when pop_cnt = BLOCK_WORDS.
  - DONE: xfer_done_o = 1. Return to IDLE when req_i = 0. Counters and FIFO cleared on DONE→IDLE.
- All ready_*, xfer_done_o and l2_req_o are registered outputs. data_o and l2_data_o are driven combinationally from the FIFO head.
- FIFO rules:
  - A push and pop in the same cycle on a non-empty, non-full FIFO leave occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits.
  - Push counter and pop counter are log2(BLOCK_WORDS)+1 bits and saturate at BLOCK_WORDS.
- Protocol errors (the offending op is ignored):
  - Push when its ready is 0: write_en_i sets bit0; l2_valid_i sets bit2.
  - Pop when its ready is 0: read_ack_i sets bit1; l2_read_ack_i sets bit3.
  - Bits 0–3 stay set until reset.
- req_i falling in CMD, WR or RD is ignored; the transfer runs to completion.

Optional Feature:
- Macro L1L2_XFER_TIMEOUT_EN.
- Defined:
  - A cycle counter runs whenever state is not IDLE; it is cleared on every state change or accepted word.
  - Reaching TIMEOUT_CYCLES sets exception_bus_o[4] (sticky), flushes the FIFO and forces DONE.
- Undefined: no counter; exception_bus_o[4] tied to 0.

Decomposition:
- Shared package l1l2_xfer_pkg holds:
  - the state enum (IDLE, CMD, WR, RD, DONE);
  - exception bit indices EXC_L1_OVF = 0, EXC_L1_UNF = 1, EXC_L2_OVF = 2, EXC_L2_UNF = 3, EXC_TIMEOUT = 4;
  - the rw encoding constants.
- Sub-module xfer_fifo: synchronous show-ahead FIFO with push/pop/flush/full/empty.
  - One instance only; source and sink are muxed by the current state.

Test Plan:
- Reset, then req_i = 1, rw_i = 0, add_i = 24'h000100 → l2_req_o = 1 next cycle with l2_add_o = 24'h000100. l2_ready_i after 3 cycles → RD. L2 pushes 4 words 0xA0..0xA3; L1 pops them in order → xfer_done_o = 1; exception_bus_o = 0.
- Write-back, add 24'h0000F0: L1 pushes 0x11..0x14 back-to-back before l2_ready_i → ready_write_o drops after the 4th word. L2 pops 0x11..0x14 in order → DONE.
- Simultaneous push/pop every cycle in RD → FIFO occupancy never exceeds 1; all 4 words delivered.
- read_ack_i while empty and write_en_i during RD → bits 1 and 0 set, FIFO unaffected. A subsequent reset_i = 1 clears them.
- reset_i asserted mid-WR after 2 pushes → next cycle state IDLE, all ready outputs 0, l2_req_o stays 0.
- With L1L2_XFER_TIMEOUT_EN and TIMEOUT_CYCLES = 16: hold l2_ready_i = 0 → after 16 cycles exception_bus_o[4] = 1 and xfer_done_o = 1.
